// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - PS/2 pin and decoded-key bundle for ps2_key_decoder
//   ps2_clk, ps2_data : raw PS/2 pins (async, idle high), driven by master
//   character, extended, key_make, key_break : held-key state and event pulses
//   rx_byte, rx_valid, frame_err : raw byte stream and error pulse for debug
interface ps2_key_decoder_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] character;
   logic       extended;
   logic       key_make;
   logic       key_break;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  character, extended, key_make, key_break, rx_byte, rx_valid, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output character, extended, key_make, key_break, rx_byte, rx_valid, frame_err
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver and make/break/extended held-key decoder
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : ps2_key_decoder_if.slave (pins in; character/extended/key_make/key_break/
//           rx_byte/rx_valid/frame_err out)
module ps2_key_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input logic              clk,
   input logic              reset,
   ps2_key_decoder_if.slave bus
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_s, data_s;
   logic                   filt;
   logic [FW-1:0]          fcnt;
   logic                   fall;

   state_t        state, state_n;
   logic [2:0]    bitcnt, bitcnt_n;
   logic [7:0]    sr, sr_n;
   logic          par, par_n;
   logic          good, err;
   logic [TW-1:0] tcnt;

   logic [7:0] rx_byte_q, character_q;
   logic       rx_valid_q, frame_err_q, extended_q, key_make_q, key_break_q;
   logic       break_pend, ext_pend;

   // Synchronisers reset to the idle-high line level so reset never fakes a fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Filtered clock only moves after FILTER_LEN consecutive samples disagreeing with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt <= 1'b1;
         fcnt <= '0;
      end else if (clk_s == filt) begin
         fcnt <= '0;
      end else if (fcnt == F_LAST) begin
         filt <= clk_s;
         fcnt <= '0;
      end else begin
         fcnt <= fcnt + 1'b1;
      end
   end

   // Strobe in the same cycle the filtered level drops, so data_s is sampled alongside it.
   assign fall = filt & ~clk_s & (fcnt == F_LAST);

   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      sr_n     = sr;
      par_n    = par;
      good     = 1'b0;
      err      = 1'b0;
      case (state)
         IDLE: if (fall && !data_s) begin
            state_n  = DATA;
            bitcnt_n = 3'd0;
         end
         DATA: if (fall) begin
            sr_n     = {data_s, sr[7:1]};
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_n = PARITY;
         end
         PARITY: if (fall) begin
            par_n   = data_s;
            state_n = STOP;
         end
         STOP: if (fall) begin
            if (data_s && (^{sr, par})) good = 1'b1;
            else                        err  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // A fall in the same cycle keeps the frame alive.
      if (state != IDLE && !fall && tcnt == T_LAST) begin
         state_n = IDLE;
         err     = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bitcnt      <= '0;
         sr          <= '0;
         par         <= 1'b0;
         tcnt        <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state       <= state_n;
         bitcnt      <= bitcnt_n;
         sr          <= sr_n;
         par         <= par_n;
         tcnt        <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
         rx_valid_q  <= good;
         frame_err_q <= err;
         if (good) rx_byte_q <= sr;
      end
   end

   // Scan-code layer: consumes each accepted byte one cycle after rx_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         character_q <= '0;
         extended_q  <= 1'b0;
         key_make_q  <= 1'b0;
         key_break_q <= 1'b0;
         break_pend  <= 1'b0;
         ext_pend    <= 1'b0;
      end else begin
         key_make_q  <= 1'b0;
         key_break_q <= 1'b0;
         if (rx_valid_q) begin
            case (rx_byte_q)
               8'hF0: break_pend <= 1'b1;
               8'hE0: ext_pend   <= 1'b1;
               8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF: ;
               default: begin
                  if (break_pend) begin
                     if (rx_byte_q == character_q && ext_pend == extended_q) begin
                        character_q <= '0;
                        extended_q  <= 1'b0;
                        key_break_q <= 1'b1;
                     end
                     break_pend <= 1'b0;
                     ext_pend   <= 1'b0;
                  end else begin
                     character_q <= rx_byte_q;
                     extended_q  <= ext_pend;
                     key_make_q  <= 1'b1;
                     ext_pend    <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign bus.character = character_q;
   assign bus.extended  = extended_q;
   assign bus.key_make  = key_make_q;
   assign bus.key_break = key_break_q;
   assign bus.rx_byte   = rx_byte_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;
   localparam int HP  = 20;
   localparam int TMO = 1000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ps2_key_decoder_if bus ();

   ps2_key_decoder #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic       brk;
      logic [7:0] ch;
      logic       ex;
   } evt_t;

   evt_t       exp_evt[$];
   logic [7:0] exp_rx[$];
   int         exp_err = 0;
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   task automatic exp_make(input logic [7:0] c, input logic e);
      evt_t v;
      v.brk = 1'b0; v.ch = c; v.ex = e;
      exp_evt.push_back(v);
   endtask

   task automatic exp_break();
      evt_t v;
      v.brk = 1'b1; v.ch = 8'h00; v.ex = 1'b0;
      exp_evt.push_back(v);
   endtask

   // Drives the first nbits of a frame; a complete good frame is pushed as an expected rx byte.
   task automatic send_frame(input logic [7:0] b, input logic good_par = 1'b1, input int nbits = 11);
      logic [10:0] bits;
      logic        p;
      p    = good_par ? ~(^b) : (^b);
      bits = {1'b1, p, b, 1'b0};
      if (good_par && nbits == 11) exp_rx.push_back(b);
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = bits[i];
         repeat (HP) @(posedge clk);
         bus.ps2_clk = 1'b0;
         repeat (HP) @(posedge clk);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
      repeat (2 * HP) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_rx.size() != 0 || exp_evt.size() != 0 || exp_err != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_rx", 32'(exp_rx.size()), 32'd0);
      chk("drain_evt", 32'(exp_evt.size()), 32'd0);
      chk("drain_err", 32'(exp_err), 32'd0);
   endtask

   task automatic chk_key(input string name, input logic [7:0] c, input logic e);
      chk({name, "_char"}, {24'h0, bus.character}, {24'h0, c});
      chk({name, "_ext"}, {31'h0, bus.extended}, {31'h0, e});
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rx_valid) begin
            chk("rx_pending", 32'(exp_rx.size() > 0), 32'd1);
            if (exp_rx.size() > 0) chk("rx_byte", {24'h0, bus.rx_byte}, {24'h0, exp_rx.pop_front()});
         end
         if (bus.key_make || bus.key_break) begin
            chk("evt_pending", 32'(exp_evt.size() > 0), 32'd1);
            if (exp_evt.size() > 0) begin
               evt_t e;
               e = exp_evt.pop_front();
               chk("evt_kind", {30'h0, bus.key_break, bus.key_make}, e.brk ? 32'd2 : 32'd1);
               chk("evt_char", {24'h0, bus.character}, {24'h0, e.ch});
               chk("evt_ext", {31'h0, bus.extended}, {31'h0, e.ex});
            end
         end
         if (bus.frame_err) begin
            chk("err_pending", 32'(exp_err > 0), 32'd1);
            if (exp_err > 0) exp_err--;
         end
      end
   end

   initial begin
      reset        = 1'b1;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset_outs", {13'h0, bus.character, bus.extended, bus.key_make, bus.key_break,
                         bus.rx_byte, bus.rx_valid, bus.frame_err}, 32'd0);
      repeat (20) @(posedge clk);

      // single make
      exp_make(8'h23, 1'b0);
      send_frame(8'h23);
      chk_key("t1", 8'h23, 1'b0);
      drain();

      // make then release of the held key
      exp_make(8'h23, 1'b0);
      send_frame(8'h23);
      send_frame(8'hF0);
      exp_break();
      send_frame(8'h23);
      chk_key("t2", 8'h00, 1'b0);
      drain();

      // last pressed wins; release of a non-held key is ignored
      exp_make(8'h23, 1'b0);
      send_frame(8'h23);
      exp_make(8'h2D, 1'b0);
      send_frame(8'h2D);
      send_frame(8'hF0);
      send_frame(8'h23);
      chk_key("t3", 8'h2D, 1'b0);
      send_frame(8'hF0);
      exp_break();
      send_frame(8'h2D);
      chk_key("t3_rel", 8'h00, 1'b0);
      drain();

      // extended make and extended break
      send_frame(8'hE0);
      exp_make(8'h75, 1'b1);
      send_frame(8'h75);
      chk_key("t4", 8'h75, 1'b1);
      send_frame(8'hE0);
      send_frame(8'hF0);
      exp_break();
      send_frame(8'h75);
      chk_key("t4_rel", 8'h00, 1'b0);
      drain();

      // parity error and timeout leave the held key alone
      exp_make(8'h1C, 1'b0);
      send_frame(8'h1C);
      exp_err++;
      send_frame(8'h1B, 1'b0);
      chk_key("t5_par", 8'h1C, 1'b0);
      drain();
      exp_err++;
      send_frame(8'h1B, 1'b1, 5);
      drain();
      chk_key("t5_tmo", 8'h1C, 1'b0);
      exp_make(8'h1B, 1'b0);
      send_frame(8'h1B);
      chk_key("t5_next", 8'h1B, 1'b0);
      send_frame(8'hAA);
      chk_key("t5_ign", 8'h1B, 1'b0);
      drain();

      // short clock glitch with data low must not start a frame
      bus.ps2_data = 1'b0;
      repeat (HP) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HP) @(posedge clk);
      bus.ps2_data = 1'b1;
      repeat (HP) @(posedge clk);
      exp_make(8'h5A, 1'b0);
      send_frame(8'h5A);
      chk_key("t6_glitch", 8'h5A, 1'b0);
      drain();

      // reset mid-frame, then a clean frame
      send_frame(8'h66, 1'b1, 6);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midreset_outs", {13'h0, bus.character, bus.extended, bus.key_make, bus.key_break,
                            bus.rx_byte, bus.rx_valid, bus.frame_err}, 32'd0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      exp_make(8'h3A, 1'b0);
      send_frame(8'h3A);
      chk_key("t6_after_reset", 8'h3A, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
